// File: rtl/trap_ctrl_if.sv
// Pipeline-to-trap-controller bundle: WB-stage requests, CSR read values in,
// CSR write strobes, fetch redirect and flush/stall controls out.
interface trap_ctrl_if #(
  parameter int XLEN = 32
);
  logic            excp_valid_i;
  logic [XLEN-1:0] excp_cause_i;
  logic [XLEN-1:0] excp_pc_i;
  logic [XLEN-1:0] excp_tval_i;
  logic            mret_valid_i;
  logic [XLEN-1:0] mtvec_rdata_i;
  logic [XLEN-1:0] mepc_rdata_i;

  logic            mcause_wen_o;
  logic            mtval_wen_o;
  logic            mepc_wen_o;
  logic [XLEN-1:0] mcause_wdata_o;
  logic [XLEN-1:0] mtval_wdata_o;
  logic [XLEN-1:0] mepc_wdata_o;
  logic            redirect_valid_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic            flush_o;
  logic            busy_o;

  modport master (
    output excp_valid_i, excp_cause_i, excp_pc_i, excp_tval_i, mret_valid_i,
           mtvec_rdata_i, mepc_rdata_i,
    input  mcause_wen_o, mtval_wen_o, mepc_wen_o,
           mcause_wdata_o, mtval_wdata_o, mepc_wdata_o,
           redirect_valid_o, redirect_pc_o, flush_o, busy_o
  );

  modport slave (
    input  excp_valid_i, excp_cause_i, excp_pc_i, excp_tval_i, mret_valid_i,
           mtvec_rdata_i, mepc_rdata_i,
    output mcause_wen_o, mtval_wen_o, mepc_wen_o,
           mcause_wdata_o, mtval_wdata_o, mepc_wdata_o,
           redirect_valid_o, redirect_pc_o, flush_o, busy_o
  );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap/MRET sequencer: records exception CSRs, redirects fetch
// and holds the pipeline flushed for a fixed number of cycles.
module trap_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  trap_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    COMMIT,
    REDIRECT,
    FLUSH
  } state_t;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  state_t          state_reg;
  logic [3:0]      cnt_reg;
  logic            kind_mret_reg;
  logic [XLEN-1:0] cause_reg;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] tval_reg;
  logic            wen_reg;
  logic            redirect_reg;
  logic            flush_reg;
  logic            busy_reg;
  logic [XLEN-1:0] target_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      kind_mret_reg <= 1'b0;
      cause_reg     <= '0;
      pc_reg        <= '0;
      tval_reg      <= '0;
      wen_reg       <= 1'b0;
      redirect_reg  <= 1'b0;
      flush_reg     <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      wen_reg      <= 1'b0;
      redirect_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // Exception has priority; a coincident MRET is simply discarded.
          if (bus.excp_valid_i) begin
            cause_reg     <= bus.excp_cause_i;
            pc_reg        <= bus.excp_pc_i & ALIGN_MASK;
            tval_reg      <= bus.excp_tval_i;
            kind_mret_reg <= 1'b0;
            wen_reg       <= 1'b1;
            flush_reg     <= 1'b1;
            busy_reg      <= 1'b1;
            state_reg     <= COMMIT;
          end else if (bus.mret_valid_i) begin
            kind_mret_reg <= 1'b1;
            redirect_reg  <= 1'b1;
            flush_reg     <= 1'b1;
            busy_reg      <= 1'b1;
            cnt_reg       <= 4'(FLUSH_CYCLES);
            state_reg     <= REDIRECT;
          end
        end
        COMMIT: begin
          redirect_reg <= 1'b1;
          cnt_reg      <= 4'(FLUSH_CYCLES);
          state_reg    <= REDIRECT;
        end
        REDIRECT: begin
          state_reg <= FLUSH;
        end
        FLUSH: begin
          if (cnt_reg <= 4'd1) begin
            cnt_reg   <= '0;
            flush_reg <= 1'b0;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Target uses the live CSR values of the REDIRECT cycle, not a snapshot.
  always_comb begin
    target_next = kind_mret_reg ? bus.mepc_rdata_i : (bus.mtvec_rdata_i & ALIGN_MASK);
  end

  assign bus.mcause_wen_o     = wen_reg;
  assign bus.mtval_wen_o      = wen_reg;
  assign bus.mepc_wen_o       = wen_reg;
  assign bus.mcause_wdata_o   = cause_reg;
  assign bus.mtval_wdata_o    = tval_reg;
  assign bus.mepc_wdata_o     = pc_reg;
  assign bus.redirect_valid_o = redirect_reg;
  assign bus.redirect_pc_o    = redirect_reg ? target_next : '0;
  assign bus.flush_o          = flush_reg;
  assign bus.busy_o           = busy_reg;

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width (matches `XLEN).
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, cycles spent in FLUSH state; legal range 1..15.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port excp_valid_i  in  1  WB-stage instruction raised an exception.
REQ-006 SHALL have port excp_cause_i  in  XLEN  exception cause code.
REQ-007 SHALL have port excp_pc_i  in  XLEN  PC of the faulting instruction.
REQ-008 SHALL have port excp_tval_i  in  XLEN  trap value (bad address or instruction).
REQ-009 SHALL have port mret_valid_i  in  1  WB-stage instruction is MRET.
REQ-010 SHALL have port mtvec_rdata_i / mepc_rdata_i  in  XLEN each  current mtvec / mepc from the CSR file.
REQ-011 SHALL have ports mcause_wen_o, mtval_wen_o, mepc_wen_o  out  1 each  CSR exception write enables.
REQ-012 SHALL have ports mcause_wdata_o, mtval_wdata_o, mepc_wdata_o  out  XLEN each  CSR exception write data.
REQ-013 SHALL have port redirect_valid_o  out  1  fetch redirect strobe.
REQ-014 SHALL have port redirect_pc_o  out  XLEN  redirect target.
REQ-015 SHALL have port flush_o  out  1  kill all non-retired instructions.
REQ-016 SHALL have port busy_o  out  1  controller not IDLE; pipeline stalls retirement.

Function
REQ-017 SHALL implement FSM states IDLE, COMMIT, REDIRECT, FLUSH.
REQ-018 IDLE: excp_valid_i=1 SHALL capture cause/pc/tval into internal registers, latch kind=TRAP, go COMMIT.
REQ-019 IDLE: mret_valid_i=1 with excp_valid_i=0 SHALL latch kind=MRET, go REDIRECT (COMMIT skipped).
REQ-020 Simultaneous excp_valid_i and mret_valid_i in IDLE: exception wins; MRET discarded.
REQ-021 COMMIT (exactly 1 cycle): mcause/mtval/mepc_wen_o=1 with captured cause/tval/pc; mepc_wdata_o bits[1:0] forced 0; next REDIRECT.
REQ-022 REDIRECT (exactly 1 cycle): redirect_valid_o=1; TRAP target = {mtvec_rdata_i[XLEN-1:2],2'b00}, MRET target = mepc_rdata_i, both sampled combinationally this cycle; next FLUSH.
REQ-023 FLUSH: SHALL last exactly FLUSH_CYCLES cycles via a down-counter loaded on REDIRECT entry, then go IDLE.
REQ-024 flush_o SHALL be 1 in COMMIT, REDIRECT and FLUSH; 0 in IDLE.
REQ-025 busy_o SHALL be 1 whenever state != IDLE.
REQ-026 excp_valid_i and mret_valid_i SHALL be ignored outside IDLE (requests during busy are dropped, no queuing).
REQ-027 All CSR wen outputs and redirect_valid_o SHALL be registered-state decodes (no combinational path from excp_valid_i/mret_valid_i).
REQ-028 Outside their active state, wen and redirect_valid_o SHALL be 0; wdata/redirect_pc values then don't-care but SHALL NOT be X after reset.
REQ-029 Latency: TRAP request to redirect_valid_o = 2 cycles; MRET = 1 cycle; request to next acceptance = 2+FLUSH_CYCLES (TRAP) or 1+FLUSH_CYCLES (MRET) cycles.
REQ-030 Back-to-back: a request presented in the first IDLE cycle after FLUSH SHALL be accepted.

Reset
REQ-031 rst=1 SHALL immediately force state IDLE, counter 0, captured registers 0, all outputs 0, independent of clk.
REQ-032 rst asserted mid-sequence SHALL abort it; no CSR write or redirect issued after rst deasserts unless a new request arrives.
REQ-033 First request SHALL be accepted on the first rising clk edge with rst=0.

Verification
REQ-034 TRAP: excp_valid_i=1, cause=2, pc=0x100, tval=0xDEAD, mtvec=0x803 -> cycle+1 three wen=1 (0x2,0xDEAD,0x100); cycle+2 redirect_valid_o=1, pc=0x800; flush_o=1 for 2+FLUSH_CYCLES cycles.
REQ-035 MRET: mret_valid_i=1, mepc=0x204 -> cycle+1 redirect_valid_o=1, pc=0x204; no wen asserted; busy_o=1 for 1+FLUSH_CYCLES cycles.
REQ-036 Simultaneous excp_valid_i and mret_valid_i -> TRAP sequence only; redirect target from mtvec.
REQ-037 Second excp_valid_i pulse during FLUSH -> dropped; exactly one set of CSR writes; new request right after FLUSH accepted.
REQ-038 rst pulsed during COMMIT -> outputs 0 asynchronously; no redirect_valid_o afterwards; FSM IDLE.
